// File: rtl/mc_ctrl_pkg.sv
// Shared state, opcode and control-field encodings for the
// multicycle MIPS control unit.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      RTYPE_EX = 4'd6,
      RTYPE_WB = 4'd7,
      ADDI_EX  = 4'd8,
      ADDI_WB  = 4'd9,
      BRANCH   = 4'd10,
      JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALU_RTYPE = 2'b00;
   localparam logic [1:0] ALU_ADD   = 2'b01;
   localparam logic [1:0] ALU_BEQ   = 2'b10;
   localparam logic [1:0] ALU_BNE   = 2'b11;

   localparam logic [1:0] SRCB_RT    = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       dst_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational decode: current state plus opcode to datapath
// controls, next state, trap and retire strobes.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned OP_W    = 6,
   parameter bit          TRAP_EN = 1'b1
) (
   input  state_t          state_i,
   input  logic [OP_W-1:0] opcode_i,
   input  logic [OP_W-1:0] op_q_i,
   input  logic            ready_i,
   output ctrl_t           ctrl_o,
   output state_t          next_o,
   output logic            illegal_o,
   output logic            done_o
);

   always_comb begin
      ctrl_o    = '0;
      next_o    = FETCH;
      illegal_o = 1'b0;
      done_o    = 1'b0;
      case (state_i)
         FETCH: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.alu_src_b = SRCB_FOUR;
            ctrl_o.alu_op    = ALU_ADD;
            ctrl_o.ir_write  = ready_i;
            ctrl_o.pc_write  = ready_i;
            next_o = ready_i ? DECODE : FETCH;
         end
         DECODE: begin
            ctrl_o.alu_src_b = SRCB_IMMSH;
            ctrl_o.alu_op    = ALU_ADD;
            unique case (1'b1)
               opcode_i == OP_W'(OP_RTYPE): next_o = RTYPE_EX;
               opcode_i == OP_W'(OP_LW),
               opcode_i == OP_W'(OP_SW):    next_o = MEMADR;
               opcode_i == OP_W'(OP_ADDI):  next_o = ADDI_EX;
               opcode_i == OP_W'(OP_BEQ),
               opcode_i == OP_W'(OP_BNE):   next_o = BRANCH;
               opcode_i == OP_W'(OP_J):     next_o = JUMP;
               default: begin
                  next_o    = FETCH;
                  illegal_o = TRAP_EN;
                  done_o    = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALU_ADD;
            next_o = (op_q_i == OP_W'(OP_LW)) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.iord     = 1'b1;
            next_o = ready_i ? MEMWB : MEMRD;
         end
         MEMWB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            done_o = 1'b1;
         end
         MEMWR: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.iord      = 1'b1;
            next_o = ready_i ? FETCH : MEMWR;
            done_o = ready_i;
         end
         RTYPE_EX: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_RT;
            ctrl_o.alu_op    = ALU_RTYPE;
            next_o = RTYPE_WB;
         end
         RTYPE_WB: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.dst_reg   = 1'b1;
            done_o = 1'b1;
         end
         ADDI_EX: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALU_ADD;
            next_o = ADDI_WB;
         end
         ADDI_WB: begin
            ctrl_o.reg_write = 1'b1;
            done_o = 1'b1;
         end
         BRANCH: begin
            ctrl_o.alu_src_a     = 1'b1;
            ctrl_o.alu_src_b     = SRCB_RT;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_source     = PCSRC_ALUOUT;
            ctrl_o.alu_op = (op_q_i == OP_W'(OP_BNE)) ? ALU_BNE : ALU_BEQ;
            done_o = 1'b1;
         end
         JUMP: begin
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.pc_source = PCSRC_JUMP;
            done_o = 1'b1;
         end
         default: next_o = FETCH;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state, latched opcode and the
// retired-instruction counter around the decode block.
module multicycle_control
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned OP_W          = 6,
   parameter int unsigned ALUOP_W       = 2,
   parameter bit          MEM_HANDSHAKE = 1'b1,
   parameter bit          TRAP_EN       = 1'b1,
   parameter int unsigned CNT_W         = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [OP_W-1:0]    opcode,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               MemtoReg,
   output logic               dstReg,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [ALUOP_W-1:0] ALUop,
   output logic [1:0]         PCSource,
   output logic               illegal_op,
   output logic               instr_done,
   output logic [CNT_W-1:0]   instr_count,
   output logic [3:0]         state_dbg
);

   state_t            state_q, state_d;
   logic [OP_W-1:0]   op_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   ctrl_t             ctrl;
   logic              ready, illegal, done;

   assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

   mc_ctrl_decode #(
      .OP_W    (OP_W),
      .TRAP_EN (TRAP_EN)
   ) u_decode (
      .state_i   (state_q),
      .opcode_i  (opcode),
      .op_q_i    (op_q),
      .ready_i   (ready),
      .ctrl_o    (ctrl),
      .next_o    (state_d),
      .illegal_o (illegal),
      .done_o    (done)
   );

   assign cnt_d = done ? cnt_q + CNT_W'(1) : cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= FETCH;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == DECODE) op_q <= opcode;
      end
   end

   // Write-type strobes are held off for the whole reset window.
   assign PCWrite     = ctrl.pc_write & rst_n;
   assign PCWriteCond = ctrl.pc_write_cond & rst_n;
   assign IRWrite     = ctrl.ir_write & rst_n;
   assign RegWrite    = ctrl.reg_write & rst_n;
   assign MemWrite    = ctrl.mem_write & rst_n;
   assign illegal_op  = illegal & rst_n;
   assign instr_done  = done & rst_n;

   assign IorD        = ctrl.iord;
   assign MemRead     = ctrl.mem_read;
   assign MemtoReg    = ctrl.mem_to_reg;
   assign dstReg      = ctrl.dst_reg;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign ALUop       = ALUOP_W'(ctrl.alu_op);
   assign PCSource    = ctrl.pc_source;
   assign instr_count = cnt_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-state controls,
// handshake stalls, trap, counter wrap and mid-instruction reset.
module tb_multicycle_control;

   logic       clk;
   logic       rst_n;
   logic       mem_ready;
   logic [5:0] opcode;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
   logic       IRWrite, MemtoReg, dstReg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, ALUop, PCSource;
   logic       illegal_op, instr_done;
   logic [3:0] instr_count, state_dbg;

   int         checks;
   int         failures;
   logic [3:0] exp_cnt;

   multicycle_control #(
      .OP_W          (6),
      .ALUOP_W       (2),
      .MEM_HANDSHAKE (1'b1),
      .TRAP_EN       (1'b1),
      .CNT_W         (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (opcode),
      .mem_ready   (mem_ready),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .MemtoReg    (MemtoReg),
      .dstReg      (dstReg),
      .RegWrite    (RegWrite),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .ALUop       (ALUop),
      .PCSource    (PCSource),
      .illegal_op  (illegal_op),
      .instr_done  (instr_done),
      .instr_count (instr_count),
      .state_dbg   (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset;
      rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'd0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (state_dbg !== 4'd0) begin
         failures++;
         $display("FAIL reset_state got=%0d exp=0", state_dbg);
      end
      checks++;
      if ({PCWrite, IRWrite, RegWrite, MemWrite, instr_done} !== 5'b0) begin
         failures++;
         $display("FAIL reset_strobes got=%b exp=00000",
                  {PCWrite, IRWrite, RegWrite, MemWrite, instr_done});
      end
      checks++;
      if (instr_count !== 4'd0) begin
         failures++;
         $display("FAIL reset_count got=%0d exp=0", instr_count);
      end
      exp_cnt = 4'd0;
      @(negedge clk);
   endtask

   task automatic test_rtype;
      rst_n = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
      #1;
      checks++;
      if ({state_dbg, IRWrite, PCWrite, MemRead, IorD, ALUSrcA, ALUSrcB, ALUop, PCSource}
          !== {4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00}) begin
         failures++;
         $display("FAIL rtype_fetch st=%0d ir=%b pc=%b mr=%b b=%b op=%b",
                  state_dbg, IRWrite, PCWrite, MemRead, ALUSrcB, ALUop);
      end
      @(negedge clk); #1;
      checks++;
      if ({state_dbg, ALUSrcA, ALUSrcB, ALUop, MemRead}
          !== {4'd1, 1'b0, 2'b11, 2'b01, 1'b0}) begin
         failures++;
         $display("FAIL rtype_decode st=%0d a=%b b=%b op=%b",
                  state_dbg, ALUSrcA, ALUSrcB, ALUop);
      end
      @(negedge clk); #1;
      checks++;
      if ({state_dbg, ALUSrcA, ALUSrcB, ALUop} !== {4'd6, 1'b1, 2'b00, 2'b00}) begin
         failures++;
         $display("FAIL rtype_ex st=%0d a=%b b=%b op=%b exp st=6 a=1 b=00 op=00",
                  state_dbg, ALUSrcA, ALUSrcB, ALUop);
      end
      @(negedge clk); #1;
      checks++;
      if ({state_dbg, RegWrite, dstReg, MemtoReg, instr_done}
          !== {4'd7, 1'b1, 1'b1, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL rtype_wb st=%0d rw=%b dst=%b m2r=%b done=%b",
                  state_dbg, RegWrite, dstReg, MemtoReg, instr_done);
      end
      exp_cnt++;
      @(negedge clk); #1;
      checks++;
      if ({state_dbg, instr_count} !== {4'd0, exp_cnt}) begin
         failures++;
         $display("FAIL rtype_retire st=%0d cnt=%0d exp st=0 cnt=%0d",
                  state_dbg, instr_count, exp_cnt);
      end
   endtask

   task automatic test_lw_stall;
      mem_ready = 1'b1; opcode = 6'b100011;
      @(negedge clk);
      #1;
      checks++;
      if (state_dbg !== 4'd1) begin
         failures++;
         $display("FAIL lw_decode got=%0d exp=1", state_dbg);
      end
      @(negedge clk);
      opcode = 6'b101011;
      #1;
      checks++;
      if ({state_dbg, ALUSrcA, ALUSrcB, ALUop} !== {4'd2, 1'b1, 2'b10, 2'b01}) begin
         failures++;
         $display("FAIL lw_memadr st=%0d a=%b b=%b op=%b",
                  state_dbg, ALUSrcA, ALUSrcB, ALUop);
      end
      @(negedge clk);
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_ready = 1'b1;
         #1;
         checks++;
         if ({state_dbg, MemRead, IorD, RegWrite} !== {4'd3, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL lw_memrd_hold%0d st=%0d mr=%b iord=%b",
                     i, state_dbg, MemRead, IorD);
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if ({state_dbg, RegWrite, MemtoReg, dstReg, instr_done}
          !== {4'd4, 1'b1, 1'b1, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL lw_memwb st=%0d rw=%b m2r=%b dst=%b done=%b",
                  state_dbg, RegWrite, MemtoReg, dstReg, instr_done);
      end
      exp_cnt++;
      @(negedge clk); #1;
      checks++;
      if ({state_dbg, instr_count} !== {4'd0, exp_cnt}) begin
         failures++;
         $display("FAIL lw_retire st=%0d cnt=%0d exp cnt=%0d",
                  state_dbg, instr_count, exp_cnt);
      end
   endtask

   task automatic test_branch(input logic [5:0] op, input logic [5:0] alt,
                              input logic [1:0] exp_op);
      mem_ready = 1'b1; opcode = op;
      @(negedge clk);
      #1;
      checks++;
      if (state_dbg !== 4'd1) begin
         failures++;
         $display("FAIL br_decode op=%b got=%0d exp=1", op, state_dbg);
      end
      @(negedge clk);
      opcode = alt;
      #1;
      checks++;
      if ({state_dbg, ALUop, PCWriteCond, PCSource, ALUSrcA, ALUSrcB, PCWrite, instr_done}
          !== {4'd10, exp_op, 1'b1, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL br_exec op=%b st=%0d aluop=%b exp=%b pwc=%b psrc=%b done=%b",
                  op, state_dbg, ALUop, exp_op, PCWriteCond, PCSource, instr_done);
      end
      exp_cnt++;
      @(negedge clk); #1;
      checks++;
      if ({state_dbg, instr_count} !== {4'd0, exp_cnt}) begin
         failures++;
         $display("FAIL br_retire op=%b st=%0d cnt=%0d exp cnt=%0d",
                  op, state_dbg, instr_count, exp_cnt);
      end
   endtask

   task automatic test_illegal;
      mem_ready = 1'b1; opcode = 6'b111111;
      @(negedge clk);
      #1;
      checks++;
      if ({state_dbg, illegal_op, instr_done, RegWrite, MemWrite}
          !== {4'd1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL illegal_decode st=%0d ill=%b done=%b rw=%b mw=%b",
                  state_dbg, illegal_op, instr_done, RegWrite, MemWrite);
      end
      exp_cnt++;
      @(negedge clk); #1;
      checks++;
      if ({state_dbg, illegal_op, instr_count} !== {4'd0, 1'b0, exp_cnt}) begin
         failures++;
         $display("FAIL illegal_next st=%0d ill=%b cnt=%0d exp cnt=%0d",
                  state_dbg, illegal_op, instr_count, exp_cnt);
      end
   endtask

   task automatic test_addi_fetch_wait;
      mem_ready = 1'b0; opcode = 6'b001000;
      @(negedge clk);
      #1;
      checks++;
      if ({state_dbg, MemRead, IRWrite, PCWrite} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL fetch_wait st=%0d mr=%b ir=%b pc=%b",
                  state_dbg, MemRead, IRWrite, PCWrite);
      end
      mem_ready = 1'b1;
      #1;
      checks++;
      if ({IRWrite, PCWrite} !== 2'b11) begin
         failures++;
         $display("FAIL fetch_ready ir=%b pc=%b exp 11", IRWrite, PCWrite);
      end
      @(negedge clk);
      @(negedge clk); #1;
      checks++;
      if ({state_dbg, ALUSrcA, ALUSrcB, ALUop} !== {4'd8, 1'b1, 2'b10, 2'b01}) begin
         failures++;
         $display("FAIL addi_ex st=%0d a=%b b=%b op=%b",
                  state_dbg, ALUSrcA, ALUSrcB, ALUop);
      end
      @(negedge clk); #1;
      checks++;
      if ({state_dbg, RegWrite, dstReg, MemtoReg, instr_done}
          !== {4'd9, 1'b1, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL addi_wb st=%0d rw=%b dst=%b done=%b",
                  state_dbg, RegWrite, dstReg, instr_done);
      end
      exp_cnt++;
      @(negedge clk);
   endtask

   task automatic test_sw;
      mem_ready = 1'b1; opcode = 6'b101011;
      @(negedge clk);
      @(negedge clk);
      opcode = 6'b100011;
      @(negedge clk); #1;
      checks++;
      if ({state_dbg, MemWrite, IorD, MemRead, instr_done}
          !== {4'd5, 1'b1, 1'b1, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL sw_memwr st=%0d mw=%b iord=%b mr=%b done=%b",
                  state_dbg, MemWrite, IorD, MemRead, instr_done);
      end
      exp_cnt++;
      @(negedge clk); #1;
      checks++;
      if ({state_dbg, instr_count} !== {4'd0, exp_cnt}) begin
         failures++;
         $display("FAIL sw_retire st=%0d cnt=%0d exp cnt=%0d",
                  state_dbg, instr_count, exp_cnt);
      end
   endtask

   task automatic run_jump;
      mem_ready = 1'b1; opcode = 6'b000010;
      @(negedge clk);
      @(negedge clk); #1;
      checks++;
      if ({state_dbg, PCWrite, PCSource, instr_done} !== {4'd11, 1'b1, 2'b10, 1'b1}) begin
         failures++;
         $display("FAIL jump st=%0d pc=%b psrc=%b done=%b",
                  state_dbg, PCWrite, PCSource, instr_done);
      end
      exp_cnt++;
      @(negedge clk);
   endtask

   task automatic test_count_wrap;
      while (exp_cnt != 4'd15) run_jump();
      #1;
      checks++;
      if (instr_count !== 4'd15) begin
         failures++;
         $display("FAIL count_full got=%0d exp=15", instr_count);
      end
      run_jump();
      #1;
      checks++;
      if ({state_dbg, instr_count} !== {4'd0, 4'd0}) begin
         failures++;
         $display("FAIL count_wrap st=%0d cnt=%0d exp st=0 cnt=0",
                  state_dbg, instr_count);
      end
   endtask

   task automatic test_reset_in_memwr;
      mem_ready = 1'b1; opcode = 6'b101011;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checks++;
      if ({state_dbg, MemWrite, instr_done} !== {4'd5, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL memwr_wait st=%0d mw=%b done=%b",
                  state_dbg, MemWrite, instr_done);
      end
      @(negedge clk); #1;
      checks++;
      if ({state_dbg, MemWrite} !== {4'd5, 1'b1}) begin
         failures++;
         $display("FAIL memwr_hold st=%0d mw=%b", state_dbg, MemWrite);
      end
      rst_n = 1'b0; mem_ready = 1'b1;
      #1;
      checks++;
      if ({MemWrite, instr_done} !== 2'b00) begin
         failures++;
         $display("FAIL memwr_rst_force mw=%b done=%b exp 00", MemWrite, instr_done);
      end
      @(negedge clk); #1;
      checks++;
      if ({state_dbg, instr_count, MemWrite} !== {4'd0, exp_cnt, 1'b0}) begin
         failures++;
         $display("FAIL memwr_rst st=%0d cnt=%0d mw=%b exp st=0 cnt=%0d mw=0",
                  state_dbg, instr_count, MemWrite, exp_cnt);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      exp_cnt = 4'd0;
      test_reset();
      test_rtype();
      test_lw_stall();
      test_branch(6'b000101, 6'b000100, 2'b11);
      test_branch(6'b000100, 6'b000101, 2'b10);
      test_illegal();
      test_addi_fetch_wait();
      test_sw();
      test_count_wrap();
      test_reset_in_memwr();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
